// File: rtl/demux2_stream_if.sv
// Producer/consumer bundle for the 1-to-2 stream demux: one valid/ready input, two valid/ready outputs, counters.
// master = the surrounding logic (producer and consumers), slave = the demux itself.
interface demux2_stream_if #(
  parameter int n     = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [n-1:0]     in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [n-1:0]     out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [n-1:0]     out1_data;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );
endinterface

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demux, one-entry slot per channel, 1-cycle latency, full throughput.
// Backpressure: in_ready follows only the selected slot (empty, or draining this cycle); the other channel never blocks it.
module demux2_stream #(
  parameter int n     = 32,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  demux2_stream_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;

  slot_t            r_st0;
  slot_t            r_st1;
  slot_t            w_st0_nxt;
  slot_t            w_st1_nxt;
  logic [n-1:0]     r_data0;
  logic [n-1:0]     r_data1;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_rdy0;
  logic w_rdy1;
  logic w_acc0;
  logic w_acc1;
  logic w_drn0;
  logic w_drn1;

  // A full slot can take a new word in the same cycle its consumer drains it.
  always_comb begin
    w_rdy0 = (r_st0 == EMPTY) || bus.out0_ready;
    w_rdy1 = (r_st1 == EMPTY) || bus.out1_ready;
    w_acc0 = bus.in_valid && !bus.in_sel && w_rdy0;
    w_acc1 = bus.in_valid &&  bus.in_sel && w_rdy1;
    w_drn0 = (r_st0 == FULL) && bus.out0_ready;
    w_drn1 = (r_st1 == FULL) && bus.out1_ready;
  end

  always_comb begin
    w_st0_nxt = r_st0;
    w_st1_nxt = r_st1;
    if (w_acc0) begin
      w_st0_nxt = FULL;
    end else if (w_drn0) begin
      w_st0_nxt = EMPTY;
    end
    if (w_acc1) begin
      w_st1_nxt = FULL;
    end else if (w_drn1) begin
      w_st1_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st0   <= EMPTY;
      r_st1   <= EMPTY;
      r_data0 <= '0;
      r_data1 <= '0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      r_st0 <= w_st0_nxt;
      r_st1 <= w_st1_nxt;
      // Data is only loaded on accept, so a drained slot keeps showing its last word.
      if (w_acc0) begin
        r_data0 <= bus.in_data;
        r_cnt0  <= r_cnt0 + 1'b1;
      end
      if (w_acc1) begin
        r_data1 <= bus.in_data;
        r_cnt1  <= r_cnt1 + 1'b1;
      end
    end
  end

  assign bus.in_ready   = bus.in_sel ? w_rdy1 : w_rdy0;
  assign bus.out0_valid = (r_st0 == FULL);
  assign bus.out1_valid = (r_st1 == FULL);
  assign bus.out0_data  = r_data0;
  assign bus.out1_data  = r_data1;
  assign bus.cnt0       = r_cnt0;
  assign bus.cnt1       = r_cnt1;

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: hand-derived vector table, directed corner sequences, and random traffic vs a queue model.
module tb_demux2_stream;
  localparam int N  = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux2_stream_if #(.n(N), .CNT_W(CW)) bus ();
  demux2_stream #(.n(N), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: each channel is a queue of capacity one; counters are plain modular integers.
  logic [N-1:0] q0[$];
  logic [N-1:0] q1[$];
  logic [N-1:0] md0, md1;
  int           mc0, mc1;

  function automatic logic m_rdy();
    if (bus.in_sel) return (q1.size() == 0) || bus.out1_ready;
    return (q0.size() == 0) || bus.out0_ready;
  endfunction

  task automatic m_update();
    logic acc;
    acc = bus.in_valid && m_rdy();
    if (rst) begin
      q0.delete(); q1.delete();
      md0 = '0; md1 = '0; mc0 = 0; mc1 = 0;
    end else begin
      if (q0.size() != 0 && bus.out0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && bus.out1_ready) void'(q1.pop_front());
      if (acc && !bus.in_sel) begin
        q0.push_back(bus.in_data); md0 = bus.in_data; mc0 = (mc0 + 1) % (1 << CW);
      end else if (acc) begin
        q1.push_back(bus.in_data); md1 = bus.in_data; mc1 = (mc1 + 1) % (1 << CW);
      end
    end
  endtask

  task automatic m_check();
    chk("m_in_ready", 64'(bus.in_ready), 64'(m_rdy()));
    chk("m_out0_valid", 64'(bus.out0_valid), 64'(q0.size() != 0));
    chk("m_out1_valid", 64'(bus.out1_valid), 64'(q1.size() != 0));
    chk("m_out0_data", 64'(bus.out0_data), 64'(md0));
    chk("m_out1_data", 64'(bus.out1_data), 64'(md1));
    chk("m_cnt0", 64'(bus.cnt0), 64'(mc0));
    chk("m_cnt1", 64'(bus.cnt1), 64'(mc1));
  endtask

  task automatic drive(input bit v, input bit s, input logic [N-1:0] d, input bit r0, input bit r1);
    bus.in_valid   = v;
    bus.in_sel     = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  // Inputs change at posedge+1; comparisons happen at the falling edge or posedge+1.
  task automatic edge_();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic step(input bit mchk);
    #4;
    if (mchk) m_check();
    edge_();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, '0, 0, 0);
    step(1);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          v;
    bit          sel;
    logic [31:0] d;
    bit          r0;
    bit          r1;
    bit          e_rdy;
    bit          e_v0;
    bit          e_v1;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    int          e_c0;
    int          e_c1;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // inputs, in_ready before the edge, then valids/data/counters after the edge
    tbl[0] = '{1, 0, 32'hA000_0000, 1, 1, 1, 1, 0, 32'hA000_0000, 32'h0,        1, 0};
    tbl[1] = '{1, 1, 32'hB000_0001, 0, 0, 1, 1, 1, 32'hA000_0000, 32'hB000_0001, 1, 1};
    tbl[2] = '{1, 1, 32'hB000_0002, 0, 0, 0, 1, 1, 32'hA000_0000, 32'hB000_0001, 1, 1};
    tbl[3] = '{1, 0, 32'hA000_0003, 1, 0, 1, 1, 1, 32'hA000_0003, 32'hB000_0001, 2, 1};
    tbl[4] = '{0, 1, 32'hDEAD_DEAD, 1, 1, 1, 0, 0, 32'hA000_0003, 32'hB000_0001, 2, 1};
    tbl[5] = '{1, 1, 32'hB000_0005, 0, 0, 1, 0, 1, 32'hA000_0003, 32'hB000_0005, 2, 2};
    tbl[6] = '{0, 0, 32'hDEAD_DEAD, 0, 0, 1, 0, 1, 32'hA000_0003, 32'hB000_0005, 2, 2};
    tbl[7] = '{1, 1, 32'hB000_0007, 0, 1, 1, 0, 1, 32'hA000_0003, 32'hB000_0007, 2, 3};

    rst = 1'b1;
    drive(1, 0, 32'h1234_5678, 1, 1);
    edge_();

    // T1: reset held two cycles with traffic offered
    step(1);
    step(1);
    rst = 1'b0;
    drive(0, 0, '0, 0, 0);
    #4;
    chk("t1_out0_valid", 64'(bus.out0_valid), 64'd0);
    chk("t1_out1_valid", 64'(bus.out1_valid), 64'd0);
    chk("t1_out0_data", 64'(bus.out0_data), 64'd0);
    chk("t1_out1_data", 64'(bus.out1_data), 64'd0);
    chk("t1_cnt0", 64'(bus.cnt0), 64'd0);
    chk("t1_cnt1", 64'(bus.cnt1), 64'd0);
    edge_();

    // T2: route one word to each channel
    drive(1, 0, 32'h8000_0000, 1, 1);
    #4;
    chk("t2_rdy0", 64'(bus.in_ready), 64'd1);
    m_check();
    edge_();
    chk("t2_out0_valid", 64'(bus.out0_valid), 64'd1);
    chk("t2_out0_data", 64'(bus.out0_data), 64'h8000_0000);
    drive(1, 1, 32'h0000_0001, 1, 1);
    step(1);
    chk("t2_out1_valid", 64'(bus.out1_valid), 64'd1);
    chk("t2_out1_data", 64'(bus.out1_data), 64'h1);
    chk("t2_out0_drained", 64'(bus.out0_valid), 64'd0);
    chk("t2_cnt0", 64'(bus.cnt0), 64'd1);
    chk("t2_cnt1", 64'(bus.cnt1), 64'd1);

    // T3: ch1 stalled, ch0 keeps flowing
    drive(0, 0, '0, 1, 1);
    step(1);
    drive(1, 1, 32'hCAFE_0001, 1, 0);
    step(1);
    chk("t3_out1_first", 64'(bus.out1_data), 64'hCAFE_0001);
    drive(1, 1, 32'hCAFE_0002, 1, 0);
    #4;
    chk("t3_stall_rdy", 64'(bus.in_ready), 64'd0);
    m_check();
    edge_();
    chk("t3_out1_hold", 64'(bus.out1_data), 64'hCAFE_0001);
    chk("t3_out1_valid", 64'(bus.out1_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h0C00 + 32'(i), 1, 0);
      #4;
      chk("t3_ch0_rdy", 64'(bus.in_ready), 64'd1);
      m_check();
      edge_();
      chk("t3_ch0_data", 64'(bus.out0_data), 64'(32'h0C00 + 32'(i)));
      chk("t3_ch1_still", 64'(bus.out1_data), 64'hCAFE_0001);
    end

    // Vector table from a clean reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #4;
      chk("tbl_in_ready", 64'(bus.in_ready), 64'(tbl[i].e_rdy));
      m_check();
      edge_();
      chk("tbl_out0_valid", 64'(bus.out0_valid), 64'(tbl[i].e_v0));
      chk("tbl_out1_valid", 64'(bus.out1_valid), 64'(tbl[i].e_v1));
      chk("tbl_out0_data", 64'(bus.out0_data), 64'(tbl[i].e_d0));
      chk("tbl_out1_data", 64'(bus.out1_data), 64'(tbl[i].e_d1));
      chk("tbl_cnt0", 64'(bus.cnt0), 64'(tbl[i].e_c0));
      chk("tbl_cnt1", 64'(bus.cnt1), 64'(tbl[i].e_c1));
    end

    // T4/T5: back-to-back streaming into ch0, then counter wrap at 256
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 32'h4000_0000 + 32'(i), 1, 1);
      #4;
      chk("t4_rdy", 64'(bus.in_ready), 64'd1);
      m_check();
      edge_();
      chk("t4_data", 64'(bus.out0_data), 64'(32'h4000_0000 + 32'(i)));
      if (i == 15)  chk("t4_cnt0_16", 64'(bus.cnt0), 64'd16);
      if (i == 254) chk("t5_cnt0_ff", 64'(bus.cnt0), 64'hFF);
    end
    chk("t5_cnt0_wrap", 64'(bus.cnt0), 64'd0);
    chk("t5_cnt1_same", 64'(bus.cnt1), 64'd0);

    // T6: reset while both slots are full and stalled
    drive(1, 0, 32'h6000_0000, 0, 0);
    step(1);
    drive(1, 1, 32'h6000_0001, 0, 0);
    step(1);
    chk("t6_pre_v0", 64'(bus.out0_valid), 64'd1);
    chk("t6_pre_v1", 64'(bus.out1_valid), 64'd1);
    rst = 1'b1;
    drive(1, 0, 32'h0BAD_0BAD, 0, 0);
    step(1);
    rst = 1'b0;
    drive(0, 0, '0, 0, 0);
    chk("t6_v0", 64'(bus.out0_valid), 64'd0);
    chk("t6_v1", 64'(bus.out1_valid), 64'd0);
    chk("t6_cnt0", 64'(bus.cnt0), 64'd0);
    chk("t6_cnt1", 64'(bus.cnt1), 64'd0);
    chk("t6_data0", 64'(bus.out0_data), 64'd0);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom(),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 5));
      step(1);
    end
    rst = 1'b0;
    drive(0, 0, '0, 1, 1);
    step(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
